// File: rtl/mem_dma_master.sv
// mem_dma_master: word-by-word memory copy engine on a native valid/ready bus.
// Optional macro MEM_DMA_RANGE_CHK_EN aborts the copy on addresses at or beyond MEM_SIZE words.
module mem_dma_master #(
  parameter int MEM_SIZE = 16384,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

`ifdef MEM_DMA_RANGE_CHK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [31:0]      MEM_WORDS = 32'(MEM_SIZE);
  localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0]      WORD_STEP = 32'd4;
  localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    WR_REQ = 3'd2,
    GAP    = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t           state_r;
  logic [31:0]      src_r;
  logic [31:0]      dst_r;
  logic [LEN_W-1:0] rem_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic             mem_valid_r;
  logic [31:0]      mem_addr_r;
  logic [3:0]       mem_wstrb_r;
  logic [31:0]      mem_wdata_r;
  logic [31:0]      src_word_s;
  logic [31:0]      dst_word_s;
  logic             xfer_s;

  // Out-of-range test; always false unless the range check is compiled in.
  function automatic logic addr_oob(input logic [31:0] a);
    return RANGE_CHK && ((a >> 5'd2) >= MEM_WORDS);
  endfunction

  assign src_word_s = src_addr & WORD_MASK;
  assign dst_word_s = dst_addr & WORD_MASK;
  // A ready strobe only completes a transfer while a request is outstanding.
  assign xfer_s     = mem_valid_r & mem_ready;

  // Copy sequencer with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= IDLE;
      src_r       <= 32'd0;
      dst_r       <= 32'd0;
      rem_r       <= LEN_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wstrb_r <= 4'b0000;
      mem_wdata_r <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            src_r   <= src_word_s;
            dst_r   <= dst_word_s;
            rem_r   <= len_words;
            error_r <= 1'b0;
            busy_r  <= 1'b1;
            if (len_words == LEN_ZERO) begin
              state_r <= FIN;
            end else if (addr_oob(src_word_s)) begin
              error_r <= 1'b1;
              state_r <= FIN;
            end else begin
              state_r     <= RD_REQ;
              mem_valid_r <= 1'b1;
              mem_wstrb_r <= 4'b0000;
              mem_addr_r  <= src_word_s;
            end
          end
        end
        RD_REQ: begin
          if (xfer_s) begin
            if (addr_oob(dst_r)) begin
              error_r     <= 1'b1;
              mem_valid_r <= 1'b0;
              state_r     <= FIN;
            end else begin
              // Write request follows the read directly, carrying the captured word.
              state_r     <= WR_REQ;
              mem_addr_r  <= dst_r;
              mem_wstrb_r <= 4'b1111;
              mem_wdata_r <= mem_rdata;
            end
          end
        end
        WR_REQ: begin
          if (xfer_s) begin
            src_r       <= src_r + WORD_STEP;
            dst_r       <= dst_r + WORD_STEP;
            rem_r       <= rem_r - LEN_ONE;
            mem_valid_r <= 1'b0;
            mem_wstrb_r <= 4'b0000;
            state_r     <= (rem_r == LEN_ONE) ? FIN : GAP;
          end
        end
        GAP: begin
          if (addr_oob(src_r)) begin
            error_r <= 1'b1;
            state_r <= FIN;
          end else begin
            state_r     <= RD_REQ;
            mem_valid_r <= 1'b1;
            mem_wstrb_r <= 4'b0000;
            mem_addr_r  <= src_r;
          end
        end
        FIN: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          mem_valid_r <= 1'b0;
          mem_wstrb_r <= 4'b0000;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign mem_valid = mem_valid_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wstrb = mem_wstrb_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_dma_master.sv
// tb_mem_dma_master: directed bench with a wait-state responder and a bus-transaction scoreboard.
module tb_mem_dma_master;
  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        error;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   wait_n      = 1;
  int   done_cnt    = 0;
  int   valid_cycles = 0;

  mem_dma_master #(.MEM_SIZE(16384), .LEN_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len_words(len_words), .busy(busy), .done(done),
    .error(error), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected read/write pairs for a copy, truncated to n_txn bus transactions.
  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n_txn);
    txn_t t;
    for (int k = 0; k < n_txn; k++) begin
      if (k % 2 == 0) begin
        t.addr  = src + 32'(4 * (k / 2));
        t.wstrb = 4'b0000;
        t.wdata = 32'd0;
      end else begin
        t.addr  = dst + 32'(4 * (k / 2));
        t.wstrb = 4'b1111;
        t.wdata = rd_data(src + 32'(4 * (k / 2)));
      end
      sb.push_back(t);
    end
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    src_addr  = src;
    dst_addr  = dst;
    len_words = len;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic finish_copy(input int done_before, input logic exp_err);
    wait_done(300);
    check("error_at_done", {31'd0, error}, {31'd0, exp_err});
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
    check("done_count", 32'(done_cnt), 32'(done_before + 1));
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Responder: wait_n wait states per request; checks every pending cycle against the scoreboard head.
  initial begin
    int   cnt;
    int   gap_run;
    logic prev_valid;
    txn_t e;
    cnt = 0;
    gap_run = 0;
    prev_valid = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_ready) cnt = 0;
      mem_ready = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (mem_valid === 1'b1) valid_cycles++;
      if (resetn !== 1'b1) begin
        cnt = 0;
        gap_run = 0;
      end else if (mem_valid === 1'b1) begin
        if (!prev_valid && gap_run != 0) check("gap_len", 32'(gap_run), 32'd1);
        gap_run = 0;
        if (sb.size() == 0) begin
          check("unexpected_req", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = sb[0];
          check("mem_addr", mem_addr, e.addr);
          check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
          if (e.wstrb == 4'b1111) check("mem_wdata", mem_wdata, e.wdata);
          if (cnt >= wait_n) begin
            mem_ready = 1'b1;
            mem_rdata = rd_data(mem_addr);
            void'(sb.pop_front());
          end else begin
            cnt++;
          end
        end
      end else begin
        cnt = 0;
        if (busy === 1'b1) gap_run++;
        else gap_run = 0;
      end
      prev_valid = (mem_valid === 1'b1) && (resetn === 1'b1);
    end
  end

  initial begin
    int dc;
    int vc;
    int n;
    resetn = 1'b0; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len_words = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Basic four-word copy, one wait state.
    wait_n = 1; dc = done_cnt;
    push_copy(32'h100, 32'h2000, 8);
    start_copy(32'h100, 32'h2000, 16'd4);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("valid_after_start", {31'd0, mem_valid}, 32'd1);
    finish_copy(dc, 1'b0);

    // Zero-length: done exactly two cycles after start, no bus traffic.
    dc = done_cnt; vc = valid_cycles;
    start_copy(32'h40, 32'h80, 16'd0);
    check("len0_done_early", {31'd0, done}, 32'd0);
    check("len0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("len0_done", {31'd0, done}, 32'd1);
    check("len0_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("len0_done_count", 32'(done_cnt), 32'(dc + 1));
    check("len0_no_valid", 32'(valid_cycles), 32'(vc));

    // Five wait states: responder checks stability on every pending cycle.
    wait_n = 5; dc = done_cnt;
    push_copy(32'h3000, 32'h4000, 4);
    start_copy(32'h3003, 32'h4002, 16'd2);
    finish_copy(dc, 1'b0);

    // Second start during a copy is ignored.
    wait_n = 2; dc = done_cnt;
    push_copy(32'h500, 32'h600, 6);
    start_copy(32'h500, 32'h600, 16'd3);
    repeat (4) @(negedge clk);
    start_copy(32'h7000, 32'h8000, 16'd1);
    finish_copy(dc, 1'b0);
    repeat (3) @(negedge clk);
    check("restart_ignored_valid", {31'd0, mem_valid}, 32'd0);
    check("restart_ignored_busy", {31'd0, busy}, 32'd0);

    // Reset during the second write abandons the copy.
    wait_n = 3; dc = done_cnt;
    push_copy(32'h900, 32'hA00, 4);
    start_copy(32'h900, 32'hA00, 16'd4);
    n = 0;
    while (!(mem_valid === 1'b1 && mem_wstrb === 4'b1111 && mem_addr === 32'hA04) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("second_write_seen", mem_addr, 32'hA04);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rst_mid_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_pending", 32'(sb.size()), 32'd1);
    sb.delete();
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt), 32'(dc));
    wait_n = 1; dc = done_cnt;
    push_copy(32'hB00, 32'hC00, 4);
    start_copy(32'hB00, 32'hC00, 16'd2);
    finish_copy(dc, 1'b0);

    // Destination crossing the end of memory.
    dc = done_cnt;
`ifdef MEM_DMA_RANGE_CHK_EN
    push_copy(32'h100, 32'hFFF8, 5);
    start_copy(32'h100, 32'hFFF8, 16'd4);
    finish_copy(dc, 1'b1);
    check("error_sticky", {31'd0, error}, 32'd1);
    start_copy(32'h0, 32'h0, 16'd0);
    check("error_cleared", {31'd0, error}, 32'd0);
    repeat (3) @(negedge clk);
`else
    push_copy(32'h100, 32'hFFF8, 8);
    start_copy(32'h100, 32'hFFF8, 16'd4);
    finish_copy(dc, 1'b0);
`endif

    // Source address wrap through 2^32.
    dc = done_cnt;
`ifdef MEM_DMA_RANGE_CHK_EN
    vc = valid_cycles;
    start_copy(32'hFFFF_FFFC, 32'h100, 16'd2);
    finish_copy(dc, 1'b1);
    check("oob_src_no_valid", 32'(valid_cycles), 32'(vc));
`else
    push_copy(32'hFFFF_FFFC, 32'h100, 4);
    start_copy(32'hFFFF_FFFC, 32'h100, 16'd2);
    finish_copy(dc, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
